serial_bit_feeder: RTL and testbench

- Upstream stage of the sequence detector.
- Accepts parallel words over a valid/ready handshake and serialises them into a one-bit-per-clock stream on `x`, which drives the detector's `x` input.
- A one-word holding buffer plus a shift register allows gapless back-to-back streaming.
- Drives `x` = 0 when idle so the detector sees defined data.

---
 rtl/serial_bit_feeder_pkg.sv | 17 +
 rtl/serial_bit_feeder.sv | 102 ++++++++++
 tb/tb_serial_bit_feeder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_bit_feeder_pkg.sv
// serial_bit_feeder_pkg
//   Shared definitions for the serial bit feeder: default word width,
//   the matching counter width, and the four FSM state names.
//   The state encoding is {active, hb_full}.
package serial_bit_feeder_pkg;

    localparam int unsigned DEFAULT_W     = 8;
    localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_W);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_LOADED    = 2'b01,
        ST_SHIFT     = 2'b10,
        ST_SHIFT_BUF = 2'b11
    } feeder_state_e;

endpackage

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
//   Accepts W-bit words over a valid/ready handshake and serialises them
//   one bit per clock on x. A one-word holding buffer in front of the
//   shift register lets the next word be loaded on the same edge that
//   shifts out the last bit, giving gapless back-to-back streaming.
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous, active-high reset
//   in_data   - parallel word to serialise (W bits)
//   in_valid  - in_data is valid this cycle
//   in_ready  - a word can be accepted this cycle (holding buffer empty)
//   x         - serial bit, 0 whenever x_valid is low
//   x_valid   - x carries a real data bit
//   busy      - shift register active or holding buffer full
module serial_bit_feeder
    import serial_bit_feeder_pkg::*;
#(
    parameter int unsigned W         = DEFAULT_W,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         x,
    output logic         x_valid,
    output logic         busy
);

    localparam int unsigned CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

    feeder_state_e    state_q, state_d;
    logic [W-1:0]     sr_q, sr_d;
    logic [W-1:0]     hb_q, hb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_en_q, ready_en_d;

    logic active, hb_full, last, accept, unload, active_d, hb_full_d;

    always_comb begin
        active    = state_q[1];
        hb_full   = state_q[0];
        last      = active & (cnt_q == LAST_CNT);
        accept    = in_valid & in_ready;
        unload    = hb_full & (~active | last);

        sr_d       = sr_q;
        hb_d       = hb_q;
        cnt_d      = cnt_q;
        active_d   = active;
        ready_en_d = 1'b1;

        if (accept) begin
            hb_d = in_data;
        end

        // Unload takes priority: on the last bit it reloads instead of idling.
        if (unload) begin
            sr_d     = hb_q;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active & ~last) begin
            if (MSB_FIRST) begin
                sr_d = {sr_q[W-2:0], 1'b0};
            end else begin
                sr_d = {1'b0, sr_q[W-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
        end else if (last) begin
            active_d = 1'b0;
        end

        hb_full_d = accept | (hb_full & ~unload);
        state_d   = feeder_state_e'({active_d, hb_full_d});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            hb_q       <= '0;
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            hb_q       <= hb_d;
            cnt_q      <= cnt_d;
            ready_en_q <= ready_en_d;
        end
    end

    // ready_en_q holds in_ready low during reset and releases it on the
    // first clock edge after reset deasserts.
    assign in_ready = ready_en_q & ~state_q[0];
    assign x_valid  = state_q[1];
    assign x        = state_q[1] & (MSB_FIRST ? sr_q[W-1] : sr_q[0]);
    assign busy     = state_q != ST_IDLE;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder
//   Three feeder instances (W=8 MSB-first, W=4 MSB-first, W=4 LSB-first)
//   checked every cycle against a word-level reference model, plus directed
//   scenario checks on the captured serial streams.
module tb_serial_bit_feeder;
    import serial_bit_feeder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] d0;
    logic [3:0] d1, d2;
    logic [2:0] vld, rdy, xo, xv, bsy;

    serial_bit_feeder #(.W(8), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .reset(reset), .in_data(d0), .in_valid(vld[0]),
        .in_ready(rdy[0]), .x(xo[0]), .x_valid(xv[0]), .busy(bsy[0]));
    serial_bit_feeder #(.W(4), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .reset(reset), .in_data(d1), .in_valid(vld[1]),
        .in_ready(rdy[1]), .x(xo[1]), .x_valid(xv[1]), .busy(bsy[1]));
    serial_bit_feeder #(.W(4), .MSB_FIRST(1'b0)) u2 (
        .clk(clk), .reset(reset), .in_data(d2), .in_valid(vld[2]),
        .in_ready(rdy[2]), .x(xo[2]), .x_valid(xv[2]), .busy(bsy[2]));

    int  wid  [3] = '{8, 4, 4};
    bit  msbf [3] = '{1'b1, 1'b1, 1'b0};

    // Reference model: the word currently on the wire, the bit position
    // within it, and the one-word buffer.
    logic        m_act [3];
    int          m_pos [3];
    logic [31:0] m_cw  [3];
    logic        m_hbf [3];
    logic [31:0] m_hb  [3];
    logic        m_ren;
    logic        acc   [3];

    logic [63:0] cap    [3];
    int          ncap   [3];
    int          run    [3];
    int          maxrun [3];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] din(input int i);
        case (i)
            0:       din = {24'd0, d0};
            1:       din = {28'd0, d1};
            default: din = {28'd0, d2};
        endcase
    endfunction

    task automatic set_in(input int i, input logic [31:0] w);
        case (i)
            0:       d0 = w[7:0];
            1:       d1 = w[3:0];
            default: d2 = w[3:0];
        endcase
    endtask

    function automatic logic exp_x(input int i);
        if (!m_act[i]) return 1'b0;
        return msbf[i] ? m_cw[i][wid[i]-1-m_pos[i]] : m_cw[i][m_pos[i]];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 1'b0; m_pos[i] = 0; m_cw[i] = '0;
            m_hbf[i] = 1'b0; m_hb[i] = '0; acc[i] = 1'b0;
        end
        m_ren = 1'b0;
    endtask

    task automatic clear_cap();
        for (int i = 0; i < 3; i++) begin
            cap[i] = '0; ncap[i] = 0; run[i] = 0; maxrun[i] = 0;
        end
    endtask

    // One clock: check outputs at negedge, advance model at posedge.
    task automatic step();
        feeder_state_e st;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            st = feeder_state_e'({m_act[i], m_hbf[i]});
            chk($sformatf("x[%0d]@%0d", i, cyc), {31'd0, xo[i]}, {31'd0, exp_x(i)});
            chk($sformatf("x_valid[%0d]@%0d", i, cyc), {31'd0, xv[i]}, {31'd0, m_act[i]});
            chk($sformatf("in_ready[%0d]@%0d", i, cyc), {31'd0, rdy[i]},
                {31'd0, m_ren & ~m_hbf[i]});
            chk($sformatf("busy[%0d]@%0d", i, cyc), {31'd0, bsy[i]},
                {31'd0, st != ST_IDLE});
            acc[i] = vld[i] & m_ren & ~m_hbf[i];
            if (xv[i]) begin
                cap[i] = {cap[i][62:0], xo[i]};
                ncap[i]++;
                run[i]++;
                if (run[i] > maxrun[i]) maxrun[i] = run[i];
            end else begin
                run[i] = 0;
            end
        end
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_act[i]) begin
                    if (m_pos[i] == wid[i] - 1) m_act[i] = 1'b0;
                    else m_pos[i]++;
                end
                if (m_hbf[i] && !m_act[i]) begin
                    m_cw[i] = m_hb[i]; m_pos[i] = 0; m_act[i] = 1'b1; m_hbf[i] = 1'b0;
                end
                if (acc[i]) begin
                    m_hbf[i] = 1'b1; m_hb[i] = din(i);
                end
            end
            m_ren = 1'b1;
        end
        cyc++;
        #1;
    endtask

    // Present a word and leave in_valid high; returns the accepting cycle.
    task automatic send(input int i, input logic [31:0] w, output int at);
        vld[i] = 1'b1;
        set_in(i, w);
        at = -1;
        for (int n = 0; n < 40 && at < 0; n++) begin
            step();
            if (acc[i]) at = cyc;
        end
        chk($sformatf("accepted[%0d]", i), {31'd0, at >= 0}, 32'd1);
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while ((m_act[i] || m_hbf[i]) && n < 80) begin
            step();
            n++;
        end
        chk($sformatf("idle_reached[%0d]", i), {31'd0, !(m_act[i] || m_hbf[i])}, 32'd1);
        step();
    endtask

    initial begin
        int a0, a1, a2, rel, lat;
        reset = 1'b1;
        vld = '0; d0 = '0; d1 = '0; d2 = '0;
        model_reset();
        clear_cap();
        step();
        step();
        chk("reset_state", {20'd0, rdy, xo, xv, bsy}, 32'd0);
        reset = 1'b0;
        rel = cyc;

        // Single word W=4: accepted on the second edge after reset.
        send(1, 32'hB, a0);
        vld[1] = 1'b0;
        chk("s1_accept_edge", a0 - rel, 32'd2);
        wait_idle(1);
        chk("s1_stream", cap[1][31:0], 32'hB);
        chk("s1_nbits", ncap[1], 32'd4);
        chk("s1_run", maxrun[1], 32'd4);

        // Back-to-back W=8.
        clear_cap();
        send(0, 32'hB6, a0);
        send(0, 32'h2D, a1);
        vld[0] = 1'b0;
        wait_idle(0);
        chk("s2_stream", cap[0][31:0], 32'hB62D);
        chk("s2_run", maxrun[0], 32'd16);

        // Backpressure with in_valid held across three words.
        clear_cap();
        send(0, 32'hA5, a0);
        send(0, 32'h3C, a1);
        send(0, 32'hE1, a2);
        vld[0] = 1'b0;
        chk("s3_third_wait", a2 - a0, 32'd10);
        wait_idle(0);
        chk("s3_stream", cap[0][31:0], 32'hA53CE1);
        chk("s3_nbits", ncap[0], 32'd24);
        chk("s3_run", maxrun[0], 32'd24);

        // LSB-first W=4: 4'b1101 leaves as 1,0,1,1.
        clear_cap();
        send(2, 32'hD, a0);
        vld[2] = 1'b0;
        wait_idle(2);
        chk("s4_stream", cap[2][31:0], 32'hB);

        // Reset after two bits of 8'hFF.
        clear_cap();
        send(0, 32'hFF, a0);
        vld[0] = 1'b0;
        for (int n = 0; n < 10 && ncap[0] < 2; n++) step();
        chk("s5_two_bits", ncap[0], 32'd2);
        reset = 1'b1;
        #1;
        chk("s5_async_x", {31'd0, xo[0]}, 32'd0);
        chk("s5_async_xv", {31'd0, xv[0]}, 32'd0);
        chk("s5_async_rdy", {31'd0, rdy[0]}, 32'd0);
        chk("s5_async_busy", {31'd0, bsy[0]}, 32'd0);
        model_reset();
        step();
        step();
        reset = 1'b0;
        clear_cap();
        send(0, 32'h81, a0);
        vld[0] = 1'b0;
        wait_idle(0);
        chk("s5_stream", cap[0][31:0], 32'h81);
        chk("s5_nbits", ncap[0], 32'd8);

        // Idle gap between two words; both see the same latency.
        clear_cap();
        send(1, 32'h9, a0);
        vld[1] = 1'b0;
        lat = 0;
        for (int n = 0; n < 10 && ncap[1] == 0; n++) begin step(); lat++; end
        chk("s6_lat1", lat, 32'd2);
        wait_idle(1);
        for (int n = 0; n < 5; n++) step();
        chk("s6_gap_bits", ncap[1], 32'd4);
        send(1, 32'h6, a0);
        vld[1] = 1'b0;
        lat = 0;
        for (int n = 0; n < 10 && ncap[1] == 4; n++) begin step(); lat++; end
        chk("s6_lat2", lat, 32'd2);
        wait_idle(1);
        chk("s6_stream", cap[1][31:0], 32'h96);

        // Random traffic on all three instances; in_data held while stalled.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!vld[i] || acc[i]) begin
                    vld[i] = ($urandom_range(0, 3) != 0);
                    set_in(i, $urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    vld[i] = 1'b0;
                end
            end
            step();
        end
        vld = '0;
        for (int i = 0; i < 3; i++) wait_idle(i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
